// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
// Bundles the request and result signals of the serial adder/subtractor.
//   master: drives start/op/sat/A/B, observes busy/done/result/flags
//   slave : the adder itself, the mirror image of master
interface serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic             sat;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_or_bout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op, sat, A, B,
    input  busy, done, result, cout_or_bout, overflow, zero, negative
  );

  modport slave (
    input  start, op, sat, A, B,
    output busy, done, result, cout_or_bout, overflow, zero, negative
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Multi-cycle adder/subtractor: one DIGIT-wide ripple slice is reused for
// WIDTH/DIGIT cycles, LSB digit first. Subtraction is A + ~B + 1.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_add_sub_if slave: start/op/sat/A/B in,
//          busy/done/result/cout_or_bout/overflow/zero/negative out
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic             clk,
  input logic             rst,
  serial_add_sub_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             last_digit;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry_q;
  logic             sat_q;
  logic [CNT_W-1:0] digit_cnt;

  logic [WIDTH-1:0] result_q;
  logic             cout_q, ovf_q, zero_q, neg_q, done_q;

  logic [WIDTH-1:0] b_eff;
  logic [DIGIT:0]   digit_full;
  logic [DIGIT-1:0] digit_sum;
  logic             carry_out;
  logic             c_msb_in;
  logic             ovf_now;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_result;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept only from IDLE, leave RUN after the last digit.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_digit = (state_q == RUN) && (digit_cnt == CNT_W'(N - 1));
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_digit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit slice. The operand registers shift right, so the current digit is
  // always in the low DIGIT bits. The carry into the digit MSB is recovered
  // as a^b^sum of that bit, which also works for DIGIT=1. The new digit is
  // shifted into the top of the sum register; the wider concatenation keeps
  // this valid when DIGIT equals WIDTH. On the last digit a_sr's top bit is
  // the sign of A, which picks the saturation clamp.
  always_comb begin
    b_eff        = bus.B ^ {WIDTH{bus.op}};
    digit_full   = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
    digit_sum    = digit_full[DIGIT-1:0];
    carry_out    = digit_full[DIGIT];
    c_msb_in     = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ digit_sum[DIGIT-1];
    ovf_now      = c_msb_in ^ carry_out;
    raw_sum      = WIDTH'({digit_sum, sum_sr} >> DIGIT);
    final_result = raw_sum;
    if (sat_q && ovf_now) begin
      final_result = a_sr[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Datapath. Visible outputs change only on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_q   <= 1'b0;
      sat_q     <= 1'b0;
      digit_cnt <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sr      <= bus.A;
        b_sr      <= b_eff;
        carry_q   <= bus.op;
        sat_q     <= bus.sat;
        digit_cnt <= '0;
      end else if (state_q == RUN) begin
        a_sr      <= a_sr >> DIGIT;
        b_sr      <= b_sr >> DIGIT;
        sum_sr    <= raw_sum;
        carry_q   <= carry_out;
        digit_cnt <= digit_cnt + CNT_W'(1);
        if (last_digit) begin
          result_q <= final_result;
          cout_q   <= carry_out;
          ovf_q    <= ovf_now;
          zero_q   <= (final_result == '0);
          neg_q    <= final_result[WIDTH-1];
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.cout_or_bout = cout_q;
  assign bus.overflow     = ovf_q;
  assign bus.zero         = zero_q;
  assign bus.negative     = neg_q;

endmodule
